// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: VGA timing generator and tile fetcher.
//
// Generates VGA timing from CLOCK_50 with an internal divide-by-two pixel enable.
// Each screen tile is one byte of video RAM. Colour, sync and blank leave the
// block aligned to each other, two pixel enables after the scan counters.
// Two display pages are supported, and the page changes only at the frame wrap.
//
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   asynchronous, active-high reset
//   vdata        in   tile byte from RAM: [5:4]=R, [3:2]=G, [1:0]=B
//   page_sel     in   requested display page, taken at the frame wrap
//   border       in   colour outside the tile grid, same format as vdata[5:0]
//   vaddr        out  tile address to RAM
//   VGA_R/G/B    out  colour channels; each 2-bit value sits in the top bits
//   VGA_HS/VS    out  sync outputs, polarity set by SYNC_NEG
//   VGA_BLANK_N  out  low outside the active area
//   pix_ce       out  pixel enable, also usable as VGA_CLK
//   frame_start  out  one-CLOCK_50 pulse following the frame wrap
//   vblank       out  high while the line counter is at or past V_ACTIVE
//   page_active  out  page currently being displayed

module vga_tile_scanner #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned SYNC_NEG  = 1,
   parameter int unsigned TILE_LOG2 = 6,
   parameter int unsigned GRID_COLS = 10,
   parameter int unsigned GRID_ROWS = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE      = 128,
   parameter int unsigned PAGE_SIZE = 80,
   parameter int unsigned VGA_BITS  = 8
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [7:0]          vdata,
   input  logic                page_sel,
   input  logic [5:0]          border,
   output logic [ADDR_W-1:0]   vaddr,
   output logic [VGA_BITS-1:0] VGA_R,
   output logic [VGA_BITS-1:0] VGA_G,
   output logic [VGA_BITS-1:0] VGA_B,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic                VGA_BLANK_N,
   output logic                pix_ce,
   output logic                frame_start,
   output logic                vblank,
   output logic                page_active
);

   localparam int unsigned HTot   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTot   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCntW  = $clog2(HTot);
   localparam int unsigned VCntW  = $clog2(VTot);
   localparam int unsigned HsOn   = H_ACTIVE + H_FP;
   localparam int unsigned HsOff  = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VsOn   = V_ACTIVE + V_FP;
   localparam int unsigned VsOff  = V_ACTIVE + V_FP + V_SYNC;
   localparam logic        SyncPol = (SYNC_NEG != 0);

   // Places a 2-bit channel in the top bits of a VGA_BITS-wide output.
   function automatic logic [VGA_BITS-1:0] expand_chan(input logic [1:0] c);
      logic [VGA_BITS-1:0] v;
      v = '0;
      v[VGA_BITS-1 -: 2] = c;
      return v;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                pix_ce_q;
   logic [HCntW-1:0]    hx_q, hx_d;
   logic [VCntW-1:0]    vy_q, vy_d;
   logic                page_q, page_d;
   logic                frame_start_q, frame_start_d;
   logic                vblank_q, vblank_d;

   // Stage 1: address plus delayed position flags.
   logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
   logic                s1_active_q, s1_active_d;
   logic                s1_in_grid_q, s1_in_grid_d;
   logic                s1_hs_q, s1_hs_d;
   logic                s1_vs_q, s1_vs_d;

   // Stage 2: output registers.
   logic [VGA_BITS-1:0] r_q, r_d;
   logic [VGA_BITS-1:0] g_q, g_d;
   logic [VGA_BITS-1:0] b_q, b_d;
   logic                hs_q, hs_d;
   logic                vs_q, vs_d;
   logic                blank_n_q, blank_n_d;

   // ---------------------------------------------------------------------
   // Stage 0: decode the scan position
   // ---------------------------------------------------------------------
   logic             hx_last, vy_last, frame_wrap;
   logic [HCntW-1:0] col;
   logic [VCntW-1:0] row;
   logic             in_grid, active, hs_raw, vs_raw;
   logic [31:0]      addr_sum;

   always_comb begin
      hx_last    = (32'(hx_q) == HTot - 1);
      vy_last    = (32'(vy_q) == VTot - 1);
      frame_wrap = pix_ce_q && hx_last && vy_last;

      col     = hx_q >> TILE_LOG2;
      row     = vy_q >> TILE_LOG2;
      in_grid = (32'(col) < GRID_COLS) && (32'(row) < GRID_ROWS);
      active  = (32'(hx_q) < H_ACTIVE) && (32'(vy_q) < V_ACTIVE);
      hs_raw  = (32'(hx_q) >= HsOn) && (32'(hx_q) < HsOff);
      vs_raw  = (32'(vy_q) >= VsOn) && (32'(vy_q) < VsOff);

      // Full-width sum; the low ADDR_W bits give the modular wrap.
      addr_sum = BASE + (page_q ? PAGE_SIZE : 32'd0)
               + 32'(row) * GRID_COLS + 32'(col);
   end

   // ---------------------------------------------------------------------
   // Next-state logic; only applied on pixel-enable cycles
   // ---------------------------------------------------------------------
   logic [5:0] colour;

   always_comb begin
      hx_d   = hx_last ? '0 : hx_q + HCntW'(1);
      vy_d   = vy_q;
      if (hx_last) begin
         vy_d = vy_last ? '0 : vy_q + VCntW'(1);
      end

      // The page only changes on the wrap into (0,0), so a frame never mixes pages.
      page_d = (hx_last && vy_last) ? page_sel : page_q;

      frame_start_d = frame_wrap;
      vblank_d      = (32'(vy_q) >= V_ACTIVE);

      vaddr_d      = in_grid ? addr_sum[ADDR_W-1:0] : vaddr_q;
      s1_active_d  = active;
      s1_in_grid_d = in_grid;
      s1_hs_d      = hs_raw;
      s1_vs_d      = vs_raw;

      // vdata here answers the vaddr set one pixel enable earlier, which
      // covers RAM read latency of zero or one CLOCK_50 cycle.
      colour = 6'd0;
      if (s1_active_q) begin
         colour = s1_in_grid_q ? vdata[5:0] : border;
      end
      r_d       = expand_chan(colour[5:4]);
      g_d       = expand_chan(colour[3:2]);
      b_d       = expand_chan(colour[1:0]);
      blank_n_d = s1_active_q;
      hs_d      = s1_hs_q ^ SyncPol;
      vs_d      = s1_vs_q ^ SyncPol;
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pix_ce_q      <= 1'b0;
         frame_start_q <= 1'b0;
         hx_q          <= '0;
         vy_q          <= '0;
         page_q        <= 1'b0;
         vblank_q      <= 1'b0;
         vaddr_q       <= ADDR_W'(BASE);
         s1_active_q   <= 1'b0;
         s1_in_grid_q  <= 1'b0;
         s1_hs_q       <= 1'b0;
         s1_vs_q       <= 1'b0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         hs_q          <= SyncPol;
         vs_q          <= SyncPol;
         blank_n_q     <= 1'b0;
      end else begin
         pix_ce_q      <= ~pix_ce_q;
         // Updated every CLOCK_50 cycle so the pulse lasts exactly one cycle.
         frame_start_q <= frame_start_d;
         if (pix_ce_q) begin
            hx_q         <= hx_d;
            vy_q         <= vy_d;
            page_q       <= page_d;
            vblank_q     <= vblank_d;
            vaddr_q      <= vaddr_d;
            s1_active_q  <= s1_active_d;
            s1_in_grid_q <= s1_in_grid_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_n_q    <= blank_n_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign vaddr       = vaddr_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign pix_ce      = pix_ce_q;
   assign frame_start = frame_start_q;
   assign vblank      = vblank_q;
   assign page_active = page_q;

   // vdata[7:6] carry no colour, and the address wraps past ADDR_W bits.
   logic unused_bits;
   assign unused_bits = ^{vdata[7:6], addr_sum[31:ADDR_W]};

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Testbench for vga_tile_scanner. The DUT runs with a reduced timing so that
// several frames fit in a short run. Expected outputs come from a position
// model: after N pixel enables the outputs show scan position N-2, vaddr
// shows the newest in-grid position up to N-1, and each frame's page is
// page_sel as it stood at the previous frame wrap.

module tb_vga_tile_scanner;

   localparam int HA = 40, HF = 4, HS = 6, HB = 6;
   localparam int VA = 30, VF = 2, VS = 2, VB = 3;
   localparam int TL = 3, COLS = 4, ROWS = 4;
   localparam int BASE = 230, PAGE = 40;
   localparam int HTOT = HA + HF + HS + HB;   // 56
   localparam int VTOT = VA + VF + VS + VB;   // 37
   localparam int FRAME = HTOT * VTOT;        // 2072 pixel enables

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] vdata;
   logic       page_sel;
   logic [5:0] border;
   logic [7:0] vaddr;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, pix_ce, frame_start, vblank, page_active;

   always #5 CLOCK_50 = ~CLOCK_50;

   vga_tile_scanner #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_NEG(1), .TILE_LOG2(TL), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
      .ADDR_W(8), .BASE(BASE), .PAGE_SIZE(PAGE), .VGA_BITS(8)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .vdata(vdata), .page_sel(page_sel),
      .border(border), .vaddr(vaddr), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .pix_ce(pix_ce),
      .frame_start(frame_start), .vblank(vblank), .page_active(page_active)
   );

   // Video RAM with selectable zero- or one-cycle read latency.
   logic [7:0] ram [256];
   logic [7:0] ram_q;
   logic       lat1;
   always @(posedge CLOCK_50) ram_q <= ram[vaddr];
   assign vdata = lat1 ? ram_q : ram[vaddr];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic chk_en = 1'b0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic       m_ce = 1'b0;
   int         m_n = 0;
   logic       m_fs = 1'b0;
   logic [5:0] m_bd = 6'd0;
   logic       page_hist [64];

   always @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         m_ce <= 1'b0;
         m_n  <= 0;
         m_fs <= 1'b0;
         page_hist[0] <= 1'b0;
      end else begin
         m_ce <= ~m_ce;
         m_fs <= 1'b0;
         if (m_ce) begin
            m_n  <= m_n + 1;
            m_bd <= border;
            if (m_n % FRAME == FRAME - 1) begin
               page_hist[(m_n / FRAME + 1) % 64] <= page_sel;
               m_fs <= 1'b1;
            end
         end
      end
   end

   function automatic int hx_of(input int p); return p % HTOT; endfunction
   function automatic int vy_of(input int p); return (p / HTOT) % VTOT; endfunction
   function automatic bit in_grid(input int p);
      return ((hx_of(p) >> TL) < COLS) && ((vy_of(p) >> TL) < ROWS);
   endfunction
   function automatic bit active_at(input int p);
      return (hx_of(p) < HA) && (vy_of(p) < VA);
   endfunction
   function automatic int addr_of(input int p);
      int a;
      a = BASE + (page_hist[(p / FRAME) % 64] ? PAGE : 0)
        + (vy_of(p) >> TL) * COLS + (hx_of(p) >> TL);
      return a % 256;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t, pix=%0d)", name, act, exp, $time, m_n);
      end
   endtask

   task automatic compare_all();
      int n, p, q, e_vaddr;
      logic [5:0] c;
      logic e_hs, e_vs, e_bl, e_vb;
      n = m_n;
      p = n - 2;
      e_vaddr = BASE;
      if (n > 0) begin
         q = n - 1;
         while (!in_grid(q)) q--;
         e_vaddr = addr_of(q);
      end
      c = 6'd0;
      e_hs = 1'b1;
      e_vs = 1'b1;
      e_bl = 1'b0;
      if (n >= 2) begin
         if (active_at(p)) c = in_grid(p) ? ram[addr_of(p)][5:0] : m_bd;
         e_hs = !(hx_of(p) >= HA + HF && hx_of(p) < HA + HF + HS);
         e_vs = !(vy_of(p) >= VA + VF && vy_of(p) < VA + VF + VS);
         e_bl = active_at(p);
      end
      e_vb = (n > 0) && (vy_of(n - 1) >= VA);
      chk("pix_ce", int'(pix_ce), int'(m_ce));
      chk("vaddr", int'(vaddr), e_vaddr);
      chk("VGA_R", int'(VGA_R), int'({c[5:4], 6'b0}));
      chk("VGA_G", int'(VGA_G), int'({c[3:2], 6'b0}));
      chk("VGA_B", int'(VGA_B), int'({c[1:0], 6'b0}));
      chk("VGA_HS", int'(VGA_HS), int'(e_hs));
      chk("VGA_VS", int'(VGA_VS), int'(e_vs));
      chk("VGA_BLANK_N", int'(VGA_BLANK_N), int'(e_bl));
      chk("vblank", int'(vblank), int'(e_vb));
      chk("frame_start", int'(frame_start), int'(m_fs));
      chk("page_active", int'(page_active), int'(page_hist[(n / FRAME) % 64]));
   endtask

   always @(negedge CLOCK_50) if (chk_en) compare_all();

   // ---------------- helpers ----------------
   task automatic wait_n(input int target);
      int k;
      k = 0;
      while (m_n != target && k < 4 * FRAME) begin
         @(negedge CLOCK_50);
         k++;
      end
      if (m_n != target) chk("wait_pixel_timeout", m_n, target);
   endtask

   // which: 0 = VGA_HS, 1 = VGA_VS, 2 = frame_start
   task automatic wait_lvl(input int which, input logic lvl, output int c);
      int k;
      logic s;
      k = 0;
      s = ~lvl;
      while (k < 6 * FRAME) begin
         @(negedge CLOCK_50);
         case (which)
            0: s = VGA_HS;
            1: s = VGA_VS;
            default: s = frame_start;
         endcase
         if (s == lvl) break;
         k++;
      end
      if (s != lvl) chk("wait_level_timeout", which, 32'(lvl));
      c = cyc;
   endtask

   // ---------------- stimulus ----------------
   int t0, t1, t2, tgt;

   initial begin
      reset = 1'b1;
      page_sel = 1'b0;
      border = 6'h03;
      lat1 = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      ram[230] = 8'h30;
      ram[231] = 8'h0C;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_pix_ce", int'(pix_ce), 0);
      chk("rst_vaddr", int'(vaddr), 230);
      chk("rst_hs", int'(VGA_HS), 1);
      chk("rst_vs", int'(VGA_VS), 1);
      chk("rst_blank_n", int'(VGA_BLANK_N), 0);
      reset = 1'b0;

      // Tile colours two pixel enables after the counters.
      wait_n(2);
      chk("px0_R", int'(VGA_R), 8'hC0);
      chk("px0_G", int'(VGA_G), 0);
      wait_n(10);
      chk("px8_G", int'(VGA_G), 8'hC0);
      chk("px8_R", int'(VGA_R), 0);
      wait_n(37);
      chk("border_B", int'(VGA_B), 8'hC0);
      chk("border_R", int'(VGA_R), 0);
      chk("border_vaddr_hold", int'(vaddr), 233);

      // Mid-frame page request must wait for the frame wrap.
      wait_n(20 * HTOT);
      page_sel = 1'b1;
      wait_n(26 * HTOT + 18 + 1);
      chk("row3_vaddr", int'(vaddr), 244);
      chk("row3_page", int'(page_active), 0);
      chk("row3_vblank", int'(vblank), 0);
      wait_n(30 * HTOT + 1);
      chk("vblank_on", int'(vblank), 1);
      wait_n(30 * HTOT + 2);
      chk("blank_n_off", int'(VGA_BLANK_N), 0);
      wait_n(FRAME);
      chk("page_switch", int'(page_active), 1);
      wait_n(FRAME + 1);
      chk("page1_tile00", int'(vaddr), 14);

      // Sync and frame timing in CLOCK_50 cycles.
      wait_lvl(0, 1'b0, t0);
      wait_lvl(0, 1'b1, t1);
      wait_lvl(0, 1'b0, t2);
      chk("hs_low_cycles", t1 - t0, 2 * HS);
      chk("hs_period_cycles", t2 - t0, 2 * HTOT);
      wait_lvl(1, 1'b0, t0);
      wait_lvl(1, 1'b1, t1);
      chk("vs_low_cycles", t1 - t0, 2 * VS * HTOT);
      wait_lvl(2, 1'b1, t0);
      wait_lvl(2, 1'b0, t1);
      chk("fs_width", t1 - t0, 1);
      wait_lvl(2, 1'b1, t2);
      chk("frame_cycles", t2 - t0, 2 * FRAME);

      // Random page requests and border changes, one-cycle RAM latency.
      lat1 = 1'b1;
      repeat (4 * FRAME) begin
         @(negedge CLOCK_50);
         if ($urandom_range(0, 299) == 0) page_sel = ~page_sel;
         if ($urandom_range(0, 499) == 0) border = 6'($urandom);
      end

      // Reset mid-frame at hx=30, vy=10.
      tgt = (m_n / FRAME + 1) * FRAME + 10 * HTOT + 30;
      wait_n(tgt);
      reset = 1'b1;
      #1;
      chk("mid_rst_R", int'(VGA_R), 0);
      chk("mid_rst_hs", int'(VGA_HS), 1);
      chk("mid_rst_vs", int'(VGA_VS), 1);
      chk("mid_rst_vaddr", int'(vaddr), 230);
      chk("mid_rst_page", int'(page_active), 0);
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (3 * FRAME) begin
         @(negedge CLOCK_50);
         if ($urandom_range(0, 299) == 0) page_sel = ~page_sel;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
